// File: rtl/typec_rx_dispatch.sv
// Type-C receive dispatcher: consumes receiver results, updates link configuration
// registers, raises data requests and hands ACK/NAK/STALL replies to the transmitter.
module typec_rx_dispatch #(
  parameter int          MAX_RETRY = 2,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_fs,
  output logic       rx_fd,
  input  logic [3:0] btype,
  input  logic [3:0] bdata,
  input  logic [7:0] filter,
  input  logic       data_busy,
  output logic       tx_fs,
  output logic [3:0] tx_btype,
  input  logic       tx_fd,
  output logic [3:0] dev_idx,
  output logic [3:0] param_idx,
  output logic [7:0] filter_cfg,
  output logic       cfg_upd,
  output logic       data_req,
  output logic       link_err
);

  localparam logic [3:0] BT_ACK    = 4'h1;
  localparam logic [3:0] BT_NAK    = 4'h2;
  localparam logic [3:0] BT_STALL  = 4'h3;
  localparam logic [3:0] BT_DIDX   = 4'h5;
  localparam logic [3:0] BT_DPARAM = 4'h6;
  localparam logic [3:0] BT_DDIDX  = 4'h7;
  localparam logic [3:0] BT_ERROR  = 4'hF;
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

  // Handshakes: each side raises its fs level and holds it until the peer's fd
  // level is seen; the peer then holds fd until fs drops.
  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_DECODE, S_RESP, S_RDONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  btype_q, btype_d;
  logic [3:0]  bdata_q, bdata_d;
  logic [7:0]  filter_q, filter_d;
  logic        rx_fd_q, rx_fd_d;
  logic        tx_fs_q, tx_fs_d;
  logic [3:0]  tx_btype_q, tx_btype_d;
  logic [3:0]  dev_idx_q, dev_idx_d;
  logic [3:0]  param_idx_q, param_idx_d;
  logic [7:0]  filter_cfg_q, filter_cfg_d;
  logic        cfg_upd_q, cfg_upd_d;
  logic        data_req_q, data_req_d;
  logic        link_err_q, link_err_d;
  logic [7:0]  retry_q, retry_d;
  logic [3:0]  last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic        do_reply;
  logic        resend;
  logic [3:0]  reply;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      btype_q      <= '0;
      bdata_q      <= '0;
      filter_q     <= '0;
      rx_fd_q      <= 1'b0;
      tx_fs_q      <= 1'b0;
      tx_btype_q   <= '0;
      dev_idx_q    <= '0;
      param_idx_q  <= '0;
      filter_cfg_q <= '0;
      cfg_upd_q    <= 1'b0;
      data_req_q   <= 1'b0;
      link_err_q   <= 1'b0;
      retry_q      <= '0;
      last_q       <= BT_ACK;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      btype_q      <= btype_d;
      bdata_q      <= bdata_d;
      filter_q     <= filter_d;
      rx_fd_q      <= rx_fd_d;
      tx_fs_q      <= tx_fs_d;
      tx_btype_q   <= tx_btype_d;
      dev_idx_q    <= dev_idx_d;
      param_idx_q  <= param_idx_d;
      filter_cfg_q <= filter_cfg_d;
      cfg_upd_q    <= cfg_upd_d;
      data_req_q   <= data_req_d;
      link_err_q   <= link_err_d;
      retry_q      <= retry_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    btype_d      = btype_q;
    bdata_d      = bdata_q;
    filter_d     = filter_q;
    rx_fd_d      = rx_fd_q;
    tx_fs_d      = tx_fs_q;
    tx_btype_d   = tx_btype_q;
    dev_idx_d    = dev_idx_q;
    param_idx_d  = param_idx_q;
    filter_cfg_d = filter_cfg_q;
    cfg_upd_d    = 1'b0;
    data_req_d   = 1'b0;
    link_err_d   = link_err_q;
    retry_d      = retry_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    do_reply     = 1'b0;
    resend       = 1'b0;
    reply        = BT_ACK;

    case (state_q)
      S_IDLE: begin
        if (rx_fs) begin
          btype_d  = btype;
          bdata_d  = bdata;
          filter_d = filter;
          rx_fd_d  = 1'b1;
          state_d  = S_LATCH;
        end
      end

      S_LATCH: begin
        if (!rx_fs) begin
          rx_fd_d = 1'b0;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (btype_q)
          BT_DIDX: begin
            dev_idx_d = bdata_q;
            cfg_upd_d = 1'b1;
            do_reply  = 1'b1;
            reply     = BT_ACK;
          end
          BT_DPARAM: begin
            param_idx_d  = bdata_q;
            filter_cfg_d = filter_q;
            cfg_upd_d    = 1'b1;
            do_reply     = 1'b1;
            reply        = BT_ACK;
          end
          BT_DDIDX: begin
            do_reply = 1'b1;
            if (bdata_q != dev_idx_q) begin
              reply = BT_STALL;
            end else if (data_busy) begin
              reply = BT_NAK;
            end else begin
              data_req_d = 1'b1;
              reply      = BT_ACK;
            end
          end
          BT_ERROR: begin
            do_reply = 1'b1;
            reply    = BT_NAK;
          end
          BT_ACK: begin
            retry_d    = '0;
            link_err_d = 1'b0;
          end
          BT_NAK: begin
            if (retry_q < RETRY_MAX) begin
              retry_d  = retry_q + 8'd1;
              do_reply = 1'b1;
              resend   = 1'b1;
              reply    = last_q;
            end else begin
              link_err_d = 1'b1;
              retry_d    = '0;
            end
          end
          BT_STALL: link_err_d = 1'b1;
          default: ;
        endcase

        if (do_reply) begin
          tx_fs_d    = 1'b1;
          tx_btype_d = reply;
          cnt_d      = '0;
          state_d    = S_RESP;
          // A resend keeps the retry history; any fresh reply restarts it.
          if (!resend) begin
            retry_d = '0;
            last_d  = reply;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RESP: begin
        if (tx_fd) begin
          tx_fs_d = 1'b0;
          state_d = S_RDONE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          tx_fs_d    = 1'b0;
          link_err_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RDONE: begin
        if (!tx_fd) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rx_fd      = rx_fd_q;
  assign tx_fs      = tx_fs_q;
  assign tx_btype   = tx_btype_q;
  assign dev_idx    = dev_idx_q;
  assign param_idx  = param_idx_q;
  assign filter_cfg = filter_cfg_q;
  assign cfg_upd    = cfg_upd_q;
  assign data_req   = data_req_q;
  assign link_err   = link_err_q;

endmodule

// File: tb/tb_typec_rx_dispatch.sv
// Bench for typec_rx_dispatch: directed scenarios followed by random packets,
// all checked against a packet-level reference model.
module tb_typec_rx_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_fs = 1'b0;
  logic       rx_fd;
  logic [3:0] btype = '0;
  logic [3:0] bdata = '0;
  logic [7:0] filter = '0;
  logic       data_busy = 1'b0;
  logic       tx_fs;
  logic [3:0] tx_btype;
  logic       tx_fd = 1'b0;
  logic [3:0] dev_idx;
  logic [3:0] param_idx;
  logic [7:0] filter_cfg;
  logic       cfg_upd;
  logic       data_req;
  logic       link_err;

  typec_rx_dispatch #(.MAX_RETRY(2), .TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst), .rx_fs(rx_fs), .rx_fd(rx_fd),
    .btype(btype), .bdata(bdata), .filter(filter), .data_busy(data_busy),
    .tx_fs(tx_fs), .tx_btype(tx_btype), .tx_fd(tx_fd),
    .dev_idx(dev_idx), .param_idx(param_idx), .filter_cfg(filter_cfg),
    .cfg_upd(cfg_upd), .data_req(data_req), .link_err(link_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse monitor, sampled at the edge that ends each pulse cycle
  int cfg_cnt = 0;
  int dreq_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (cfg_upd === 1'b1) cfg_cnt++;
    if (data_req === 1'b1) dreq_cnt++;
    if (cfg_upd === 1'b1 && data_req === 1'b1) both_cnt++;
  end

  // reference model of the link configuration and reply policy
  logic [3:0] m_dev, m_param, m_last;
  logic [7:0] m_filt;
  logic       m_err;
  int         m_retry;

  task automatic model_reset();
    m_dev = 0; m_param = 0; m_last = 4'h1; m_filt = 0; m_err = 0; m_retry = 0;
  endtask

  task automatic model_pkt(input logic [3:0] bt, input logic [3:0] bd, input logic [7:0] flt,
                           input logic busy, output logic [3:0] rep, output int cfg,
                           output int dreq);
    logic fresh;
    rep = 0; cfg = 0; dreq = 0; fresh = 1'b1;
    case (bt)
      4'h5: begin m_dev = bd; cfg = 1; rep = 4'h1; end
      4'h6: begin m_param = bd; m_filt = flt; cfg = 1; rep = 4'h1; end
      4'h7: begin
        if (bd != m_dev) rep = 4'h3;
        else if (busy) rep = 4'h2;
        else begin rep = 4'h1; dreq = 1; end
      end
      4'hF: rep = 4'h2;
      4'h1: begin m_retry = 0; m_err = 0; end
      4'h2: begin
        if (m_retry < 2) begin m_retry++; rep = m_last; fresh = 1'b0; end
        else begin m_err = 1; m_retry = 0; end
      end
      4'h3: m_err = 1;
      default: ;
    endcase
    if (rep != 0 && fresh) begin m_retry = 0; m_last = rep; end
  endtask

  function automatic logic [24:0] all_outs();
    return {rx_fd, tx_fs, tx_btype, dev_idx, param_idx, filter_cfg, cfg_upd, data_req, link_err};
  endfunction

  // driver: one packet through the receiver handshake, then the reply handshake.
  // mode 0 = transmitter accepts after dly cycles (dly<0 random), 1 = never accepts,
  // 2 = reset asserted while the reply is pending.
  task automatic do_pkt(input logic [3:0] bt, input logic [3:0] bd, input logic [7:0] flt,
                        input logic busy, input int mode, input int dly);
    logic [3:0] rep, exp_bt;
    int cfg, dreq, c0, d0, b0, lat, k, d;
    model_pkt(bt, bd, flt, busy, rep, cfg, dreq);
    if (rep != 0) exp_q.push_back(rep);
    @(negedge clk);
    @(negedge clk);
    c0 = cfg_cnt; d0 = dreq_cnt; b0 = both_cnt;
    btype = bt; bdata = bd; filter = flt; data_busy = busy; rx_fs = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rx_fd !== 1'b1 && lat < 4);
    check("rx_fd_latency", lat, 1);
    rx_fs = 1'b0;
    @(negedge clk);
    check("rx_fd_release", rx_fd, 0);
    @(negedge clk);
    check("tx_fs_rise", tx_fs, (rep != 0));
    if (rep != 0) begin
      exp_bt = exp_q.pop_front();
      check("tx_btype", tx_btype, exp_bt);
      if (mode == 0) begin
        d = (dly < 0) ? $urandom_range(0, 3) : dly;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("tx_fs_hold", tx_fs, 1);
          check("tx_btype_hold", tx_btype, exp_bt);
        end
        tx_fd = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (tx_fs === 1'b1 && k < 5);
        check("tx_fs_drop_after_fd", k, 1);
        tx_fd = 1'b0;
      end else if (mode == 1) begin
        k = 1;
        while (tx_fs === 1'b1 && k < 40) begin
          @(negedge clk);
          if (tx_fs === 1'b1) k++;
        end
        check("timeout_cycles", k, 16);
        m_err = 1;
      end else begin
        #2 rst = 1'b1;
        #1 check("async_reset_outs", all_outs(), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    if (mode != 2 || rep == 0) begin
      check("cfg_upd_pulses", cfg_cnt - c0, cfg);
      check("data_req_pulses", dreq_cnt - d0, dreq);
    end
    check("pulse_overlap", both_cnt - b0, 0);
    check("dev_idx", dev_idx, m_dev);
    check("param_idx", param_idx, m_param);
    check("filter_cfg", filter_cfg, m_filt);
    check("link_err", link_err, m_err);
    check("tx_fs_idle", tx_fs, 0);
  endtask

  // stimulus
  initial begin
    logic [3:0] codes [12];
    logic [3:0] bt;
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7, 4'h7, 4'h8, 4'hF};
    model_reset();
    #12;
    check("reset_outs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;

    do_pkt(4'h5, 4'h3, 8'h00, 1'b0, 0, 2);  // DIDX 3
    do_pkt(4'h6, 4'hA, 8'h5C, 1'b0, 0, 1);  // DPARAM A/5C
    do_pkt(4'h7, 4'h3, 8'h00, 1'b0, 0, 0);  // DDIDX match, idle
    do_pkt(4'h7, 4'h3, 8'h00, 1'b1, 0, 0);  // DDIDX match, busy
    do_pkt(4'h7, 4'h4, 8'h00, 1'b0, 0, 0);  // DDIDX mismatch -> STALL
    for (int i = 0; i < 3; i++) do_pkt(4'h2, 4'h0, 8'h00, 1'b0, 0, -1);
    do_pkt(4'h1, 4'h0, 8'h00, 1'b0, 0, 0);  // host ACK clears link_err
    do_pkt(4'h5, 4'h6, 8'h00, 1'b0, 1, 0);  // transmitter timeout
    do_pkt(4'h0, 4'h0, 8'h00, 1'b0, 0, 0);  // accepted after timeout
    do_pkt(4'h5, 4'h9, 8'h00, 1'b0, 2, 0);  // reset while replying
    do_pkt(4'h5, 4'h2, 8'h00, 1'b0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      bt = codes[$urandom_range(0, 11)];
      do_pkt(bt, 4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 1 : 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
